// File: rtl/vbuffer_feeder.sv
// ============================================================================
// vbuffer_feeder : fetches 3-byte pixel groups from video memory into a shadow
//                  and strobes them into the pixel unpack buffer on a trigger.
// Revision 1.0
// ============================================================================
`default_nettype none

module vbuffer_feeder #(
  parameter int IWIDTH       = 2,
  parameter int BPP          = 6,
  parameter int PSIZE        = 4,
  parameter int CLKS_PER_PIX = 2,
  parameter int AWIDTH       = 17,
  parameter int BASE_ADDR    = 0,
  parameter int FRAME_BYTES  = 57600
) (
  input  logic              PixelClk,
  input  logic              Reset,
  input  logic              FrameStart,
  input  logic [IWIDTH-1:0] ReadIndex,
  input  logic              LoadEn,
  output logic [AWIDTH-1:0] MemAddr,
  output logic              MemReq,
  input  logic              MemAck,
  input  logic [7:0]        MemData,
  output logic              ReqWrite,
  output logic [IWIDTH-1:0] WriteIndex,
  output logic [7:0]        DataOut,
  output logic              Underrun
);

  localparam int NBYTES = PSIZE * BPP / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0]     c_LAST_CNT   = CW'(NBYTES - 1);
  localparam logic [IWIDTH-1:0] c_LAST_IDX   = IWIDTH'(NBYTES - 1);
  localparam logic [AWIDTH-1:0] c_FIRST_ADDR = AWIDTH'(BASE_ADDR);
  localparam logic [AWIDTH-1:0] c_LAST_ADDR  = AWIDTH'(BASE_ADDR + FRAME_BYTES - 1);

  if (CLKS_PER_PIX < 2) begin : g_cpp_check
    $error("vbuffer_feeder: CLKS_PER_PIX below 2 leaves no room for the 6-clock transfer");
  end

  typedef enum logic {F_FILL = 1'b0, F_FULL = 1'b1} fstate_t;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_HI = 2'd1, T_LO = 2'd2} tstate_t;

  fstate_t           r_fstate;
  tstate_t           r_tstate;
  logic [CW-1:0]     r_cnt;
  logic [7:0]        r_shadow [NBYTES];
  logic [7:0]        r_xfer   [NBYTES];
  logic              r_discard;
  logic              r_mem_req;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [IWIDTH-1:0] r_ri_prev;
  logic              r_underrun;
  logic [IWIDTH-1:0] r_tidx;
  logic              r_req_write;
  logic [IWIDTH-1:0] r_wr_idx;
  logic [7:0]        r_data_out;

  logic              w_trigger;
  logic              w_take;
  logic              w_skip;
  logic [AWIDTH-1:0] w_next_addr;
  logic [IWIDTH-1:0] w_next_idx;

  // FrameStart masks the trigger in the same cycle
  assign w_trigger   = (ReadIndex == IWIDTH'(1)) && (r_ri_prev == '0) && !FrameStart;
  assign w_take      = w_trigger && LoadEn && (r_fstate == F_FULL) && (r_tstate == T_IDLE);
  assign w_skip      = w_trigger && LoadEn && (r_fstate != F_FULL);
  assign w_next_addr = (r_mem_addr == c_LAST_ADDR) ? c_FIRST_ADDR : r_mem_addr + 1'b1;
  assign w_next_idx  = r_tidx + 1'b1;

  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      r_fstate   <= F_FILL;
      r_cnt      <= '0;
      r_discard  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= c_FIRST_ADDR;
    end else if (FrameStart) begin
      r_fstate <= F_FILL;
      r_cnt    <= '0;
      if (r_mem_req && !MemAck) begin
        r_discard <= 1'b1;
      end else begin
        r_discard  <= 1'b0;
        r_mem_addr <= c_FIRST_ADDR;
        r_mem_req  <= 1'b1;
      end
    end else if (r_discard) begin
      // outstanding read finishes, its byte is dropped
      if (MemAck) begin
        r_discard  <= 1'b0;
        r_mem_addr <= c_FIRST_ADDR;
      end
    end else begin
      case (r_fstate)
        F_FILL: begin
          if (r_mem_req && MemAck) begin
            r_shadow[r_cnt] <= MemData;
            r_mem_addr      <= w_next_addr;
            if (r_cnt == c_LAST_CNT) begin
              r_fstate  <= F_FULL;
              r_mem_req <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_mem_req <= 1'b1;
          end
        end
        F_FULL: begin
          if (w_take) begin
            r_fstate  <= F_FILL;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
          end
        end
        default: r_fstate <= F_FILL;
      endcase
    end
  end

  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      r_tstate    <= T_IDLE;
      r_tidx      <= '0;
      r_req_write <= 1'b0;
      r_wr_idx    <= '0;
      r_data_out  <= '0;
    end else begin
      case (r_tstate)
        T_IDLE: begin
          if (w_take) begin
            r_xfer      <= r_shadow;
            r_tstate    <= T_HI;
            r_tidx      <= '0;
            r_req_write <= 1'b1;
            r_wr_idx    <= '0;
            r_data_out  <= r_shadow[0];
          end
        end
        T_HI: begin
          r_req_write <= 1'b0;
          r_tstate    <= T_LO;
        end
        T_LO: begin
          if (r_tidx == c_LAST_IDX) begin
            r_tstate <= T_IDLE;
          end else begin
            r_tidx      <= w_next_idx;
            r_tstate    <= T_HI;
            r_req_write <= 1'b1;
            r_wr_idx    <= w_next_idx;
            r_data_out  <= r_xfer[w_next_idx];
          end
        end
        default: r_tstate <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      r_ri_prev  <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_ri_prev <= ReadIndex;
      if (w_skip) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign MemAddr    = r_mem_addr;
  assign MemReq     = r_mem_req;
  assign ReqWrite   = r_req_write;
  assign WriteIndex = r_wr_idx;
  assign DataOut    = r_data_out;
  assign Underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_vbuffer_feeder.sv
// ============================================================================
// tb_vbuffer_feeder : directed self-checking bench for vbuffer_feeder.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vbuffer_feeder;

  // short frame so the address wrap is reachable quickly
  localparam int TB_FRAME = 12;

  logic        PixelClk = 1'b0;
  logic        Reset;
  logic        FrameStart;
  logic [1:0]  ReadIndex;
  logic        LoadEn;
  logic [16:0] MemAddr;
  logic        MemReq;
  logic        MemAck;
  logic [7:0]  MemData;
  logic        ReqWrite;
  logic [1:0]  WriteIndex;
  logic [7:0]  DataOut;
  logic        Underrun;

  int n_checks = 0;
  int n_errors = 0;
  int ack_gap  = 1;
  int gap_cnt  = 0;
  int ack_seq  = 0;
  int rw_count = 0;
  int snap;
  int ack_q[$];

  always #5 PixelClk = ~PixelClk;

  vbuffer_feeder #(.FRAME_BYTES(TB_FRAME)) u_dut (
    .PixelClk  (PixelClk),
    .Reset     (Reset),
    .FrameStart(FrameStart),
    .ReadIndex (ReadIndex),
    .LoadEn    (LoadEn),
    .MemAddr   (MemAddr),
    .MemReq    (MemReq),
    .MemAck    (MemAck),
    .MemData   (MemData),
    .ReqWrite  (ReqWrite),
    .WriteIndex(WriteIndex),
    .DataOut   (DataOut),
    .Underrun  (Underrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PixelClk);
    #2;
  endtask

  // memory responder: data is A0 + running ack number
  initial begin
    MemAck  = 1'b0;
    MemData = 8'h00;
    forever begin
      @(posedge PixelClk);
      #1;
      MemAck = 1'b0;
      if (MemReq === 1'b1 && Reset === 1'b0) begin
        if (gap_cnt >= ack_gap) begin
          MemAck  = 1'b1;
          MemData = 8'hA0 + 8'(ack_seq);
          ack_q.push_back(int'(MemAddr));
          ack_seq++;
          gap_cnt = 0;
        end else begin
          gap_cnt++;
        end
      end else begin
        gap_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge PixelClk);
      #1;
      if (ReqWrite === 1'b1) rw_count++;
    end
  end

  task automatic trigger(input logic le);
    ReadIndex = 2'd0;
    LoadEn    = le;
    tick;
    ReadIndex = 2'd1;
    tick;
  endtask

  task automatic check_xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp_b [3];
    exp_b = '{b0, b1, b2};
    for (int k = 0; k < 6; k++) begin
      check_val($sformatf("xfer_rw%0d", k), ReqWrite, (k % 2 == 0));
      if (k % 2 == 0) begin
        check_val($sformatf("xfer_idx%0d", k), WriteIndex, k / 2);
        check_val($sformatf("xfer_data%0d", k), DataOut, exp_b[k / 2]);
      end
      tick;
    end
    ReadIndex = 2'd2;
  endtask

  task automatic wait_full(input int n);
    for (int i = 0; i < 300; i++) begin
      if (ack_q.size() >= n && MemReq === 1'b0) break;
      tick;
    end
    check_val("fill_acks", ack_q.size(), n);
    check_val("fill_req", MemReq, 0);
  endtask

  initial begin
    Reset      = 1'b1;
    FrameStart = 1'b0;
    ReadIndex  = 2'd0;
    LoadEn     = 1'b0;
    tick;
    tick;
    check_val("rst_req", MemReq, 0);
    check_val("rst_addr", MemAddr, 0);
    check_val("rst_rw", ReqWrite, 0);
    check_val("rst_idx", WriteIndex, 0);
    check_val("rst_data", DataOut, 0);
    check_val("rst_unr", Underrun, 0);
    Reset = 1'b0;

    wait_full(3);
    check_val("ack_addr0", ack_q[0], 0);
    check_val("ack_addr1", ack_q[1], 1);
    check_val("ack_addr2", ack_q[2], 2);
    check_val("full_addr", MemAddr, 3);

    trigger(1'b1);
    check_val("refill_req", MemReq, 1);
    check_val("refill_addr", MemAddr, 3);
    check_xfer(8'hA0, 8'hA1, 8'hA2);
    check_val("unr_clean", Underrun, 0);

    wait_full(6);
    snap = rw_count;
    trigger(1'b0);
    repeat (8) tick;
    check_val("le0_rw", rw_count, snap);
    check_val("le0_req", MemReq, 0);
    check_val("le0_addr", MemAddr, 6);
    check_val("le0_acks", ack_q.size(), 6);
    ReadIndex = 2'd2;

    ack_gap = 20;
    trigger(1'b1);
    check_xfer(8'hA3, 8'hA4, 8'hA5);
    snap = rw_count;
    trigger(1'b1);
    check_val("unr_set", Underrun, 1);
    repeat (7) tick;
    check_val("unr_rw", rw_count, snap);
    ReadIndex = 2'd2;

    wait_full(9);
    ack_gap = 1;
    trigger(1'b1);
    check_xfer(8'hA6, 8'hA7, 8'hA8);

    wait_full(12);
    check_val("wrap_last", ack_q[11], TB_FRAME - 1);
    check_val("wrap_addr", MemAddr, 0);

    ack_gap = 4;
    trigger(1'b1);
    check_xfer(8'hA9, 8'hAA, 8'hAB);

    for (int i = 0; i < 60; i++) begin
      if (MemReq === 1'b1 && MemAddr == 17'd1 && MemAck === 1'b0) break;
      tick;
    end
    check_val("fs_pend_addr", MemAddr, 1);
    FrameStart = 1'b1;
    tick;
    FrameStart = 1'b0;
    wait_full(17);
    check_val("fs_ack12", ack_q[12], 0);
    check_val("fs_ack13", ack_q[13], 1);
    check_val("fs_ack14", ack_q[14], 0);
    check_val("fs_ack15", ack_q[15], 1);
    check_val("fs_ack16", ack_q[16], 2);
    check_val("fs_unr_kept", Underrun, 1);
    trigger(1'b1);
    check_xfer(8'hAE, 8'hAF, 8'hB0);

    wait_full(20);
    trigger(1'b1);
    check_val("rst_hi0", ReqWrite, 1);
    tick;
    tick;
    check_val("rst_hi1_rw", ReqWrite, 1);
    check_val("rst_hi1_idx", WriteIndex, 1);
    check_val("rst_hi1_data", DataOut, 8'hB2);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    check_val("mid_rst_rw", ReqWrite, 0);
    check_val("mid_rst_req", MemReq, 0);
    check_val("mid_rst_addr", MemAddr, 0);
    check_val("mid_rst_unr", Underrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
